seq_approx_multiplier: RTL
==========================

// Module: seq_approx_multiplier
// PURPOSE
//  Parametrised, iterative unsigned shift-add multiplier. Successor to the 16-bit
//  combinational traditional multiplier: generic WIDTH, valid/ready handshakes,
//  per-operation approximate mode (low multiplier bits dropped) and early
//  termination. Sits in the multiplier block family as an area-lean alternative.
// PARAMETERS
//  WIDTH       16  operand width in bits; result is 2*WIDTH bits (WIDTH >= 4)
//  TRUNC_BITS  4   multiplier LSBs ignored in approx mode (0 <= TRUNC_BITS < WIDTH)
// PORTS
//  clk_i        in   1        clock, rising edge
//  rst_ni       in   1        asynchronous reset, active low
//  in_valid_i   in   1        operands/mode valid
//  in_ready_o   out  1        block can accept an operation
//  operand1_i   in   WIDTH    multiplicand (unsigned)
//  operand2_i   in   WIDTH    multiplier (unsigned)
//  approx_i     in   1        1 = approximate mode for this operation
//  out_valid_o  out  1        result_o valid
//  out_ready_i  in   1        consumer accepts result
//  result_o     out  2*WIDTH  product
//  busy_o       out  1        high in CALC or DONE
// BEHAVIOUR
//  - Reset (rst_ni=0, asynchronous): state IDLE; in_ready_o=1; out_valid_o=0;
//    busy_o=0; result_o=0; internal regs cleared. Reset mid-op aborts; no result.
//  - States: IDLE -> CALC on accept (in_valid_i & in_ready_o at clock edge);
//    CALC -> DONE after last iteration; DONE -> IDLE on out_valid_o & out_ready_i.
//  - in_ready_o=1 only in IDLE. Inputs, including approx_i, are sampled only at
//    accept; later input changes have no effect on the operation.
//  - Effective multiplier M = operand2_i, with bits [TRUNC_BITS-1:0] forced to 0
//    when approx_i=1. Start bit index s = TRUNC_BITS if approx, else 0.
//  - CALC: one multiplier bit per cycle, starting at index s. If the bit is 1,
//    add (operand1 << index) into the 2*WIDTH accumulator. Terminates after
//    processing bit WIDTH-1, or after bit k when M[WIDTH-1:k+1] == 0
//    (early termination).
//  - CALC cycle count C = max(1, msb(M) - s + 1); C = 1 when M == 0.
//    out_valid_o rises on the edge C+1 after the accept edge.
//  - result_o = operand1 * M exactly, never overflows 2*WIDTH bits. With
//    approx_i=0 the result equals the full product.
//  - DONE: out_valid_o=1 and result_o held stable until out_ready_i is sampled
//    high. Then out_valid_o=0 and in_ready_o=1 on the next cycle; result_o
//    keeps its last value.
//  - No result/accept overlap: a new operation is accepted no earlier than
//    the cycle after the handshake in which the previous result was taken.
//  - operand1 == 0 takes no shortcut; latency is set only by M.
// TESTING
//  1. Reset with in_valid_i=1 -> in_ready_o=1, out_valid_o=0, result_o=0; no
//     accept while rst_ni=0.
//  2. 0xFFFF*0xFFFF, exact -> result_o=0xFFFE0001, C=16, out_valid_o at edge
//     17 after accept.
//  3. 0x5555*0xAAAA, exact -> 0x38E31C72, C=16. 0x1111*0x2000, exact ->
//     0x02222000, C=14 (early termination).
//  4. Approx mode, TRUNC_BITS=4: 0x1111*0x2000 -> 0x02222000, C=10.
//     0x0003*0x000F -> result 0, C=1. 0x0001*0x001F -> 0x00000010.
//  5. Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> out_valid_o and
//     result_o stable, in_ready_o=0, operand changes ignored. Then
//     out_ready_i=1 -> IDLE next cycle.
//  6. Assert rst_ni=0 mid-CALC -> immediate IDLE with outputs at reset values.
//     Next op 0x0002*0x0003 -> 0x00000006.

Source files
------------

// File: rtl/seq_approx_multiplier.sv
// Iterative unsigned shift-add multiplier with valid/ready handshakes.
// An optional approximate mode drops the low multiplier bits, and the loop stops early once no set bits remain.
module seq_approx_multiplier #(
  parameter int WIDTH      = 16,
  parameter int TRUNC_BITS = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   operand1_i,
  input  logic [WIDTH-1:0]   operand2_i,
  input  logic               approx_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               busy_o
);

  localparam int RW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] KEEP_MASK = {WIDTH{1'b1}} << TRUNC_BITS;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    result_q, result_d;
  logic             last_q, last_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] m_eff;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    result_d    = result_q;
    last_d      = last_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    m_eff       = operand2_i;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          // The multiplicand is pre-shifted to the start bit index, so CALC always works on the LSB.
          if (approx_i) begin
            m_eff    = operand2_i & KEEP_MASK;
            mplier_d = m_eff >> TRUNC_BITS;
            mcand_d  = RW'(operand1_i) << TRUNC_BITS;
          end else begin
            mplier_d = operand2_i;
            mcand_d  = RW'(operand1_i);
          end
          acc_d      = '0;
          last_d     = 1'b0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = CALC;
        end
      end
      CALC: begin
        if (last_q) begin
          result_d    = acc_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          // Stop once no higher multiplier bits remain.
          if (mplier_q[WIDTH-1:1] == '0) last_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: all datapath registers are cleared too, so an aborted operation leaves no partial result behind.
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign busy_o      = busy_q;

endmodule
